// File: rtl/fetch_pc_unit.sv
// Fetch program counter with a return-address stack.
// Picks the next fetch address from reset, an execute redirect, a RAS pop,
// a decode jump, a stall hold or the sequential increment. All state
// changes on the falling clock edge.
module fetch_pc_unit #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int                INSTR_BYTES  = 4,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_addr,
  input  logic                         jump_valid,
  input  logic [XLEN-1:0]              jump_addr,
  input  logic                         call,
  input  logic [XLEN-1:0]              call_ret_addr,
  input  logic                         ret,
  output logic [XLEN-1:0]              pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ret_miss
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;
  localparam int PW = $clog2(RAS_DEPTH);
  // Clears the low address bits below instruction alignment.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_top;
  logic            r_ovf;
  logic            r_miss;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];

  logic            w_call;
  logic            w_ret;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic [XLEN-1:0] w_top_addr;
  logic [PW-1:0]   w_wr_idx;
  logic [PW-1:0]   w_top_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_ovf_set;
  logic [XLEN-1:0] w_pc_nxt;

  // A redirect means decode was on the wrong path: drop its call/ret.
  assign w_call     = call & ~redirect_valid;
  assign w_ret      = ret  & ~redirect_valid;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(RAS_DEPTH));
  assign w_pop      = w_ret & ~w_empty;
  assign w_top_addr = r_ras[r_top];

  // RAS pointer/count bookkeeping and next-PC priority selection.
  always_comb begin
    w_wr_idx    = r_top + PW'(1);
    w_top_nxt   = r_top;
    w_count_nxt = r_count;
    w_ovf_set   = 1'b0;
    if (w_call && w_pop) begin
      // Swap: return through the old top, the call replaces it in place.
      w_wr_idx = r_top;
    end else if (w_call) begin
      // Circular push; when full the pointer lands on the oldest entry.
      w_top_nxt = r_top + PW'(1);
      if (w_full) w_ovf_set = 1'b1;
      else        w_count_nxt = r_count + CW'(1);
    end else if (w_pop) begin
      w_top_nxt   = r_top - PW'(1);
      w_count_nxt = r_count - CW'(1);
    end

    if (redirect_valid)  w_pc_nxt = redirect_addr & ALIGN_MASK;
    else if (w_pop)      w_pc_nxt = w_top_addr & ALIGN_MASK;
    else if (jump_valid) w_pc_nxt = jump_addr & ALIGN_MASK;
    else if (stall)      w_pc_nxt = r_pc;
    else                 w_pc_nxt = r_pc + XLEN'(INSTR_BYTES);
  end

  // Control state: PC, RAS pointer/count and status flags.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_pc    <= RESET_VECTOR;
      r_count <= '0;
      r_top   <= '0;
      r_ovf   <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_count <= w_count_nxt;
      r_top   <= w_top_nxt;
      r_ovf   <= r_ovf | w_ovf_set;
      r_miss  <= w_ret & w_empty;
    end
  end

  // RAS storage; contents are don't-care after reset so no reset here.
  always_ff @(negedge clk) begin
    if (!rst && w_call) r_ras[w_wr_idx] <= call_ret_addr;
  end

  assign pc           = r_pc;
  assign ras_count    = r_count;
  assign ras_overflow = r_ovf;
  assign ret_miss     = r_miss;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, increment, stall, jump,
// redirect priority, RAS push/pop/overflow/miss, swap, wrap, mid-run reset.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, jump_valid, call, ret;
  logic [31:0] redirect_addr, jump_addr, call_ret_addr;
  logic [31:0] pc;
  logic [2:0]  ras_count;
  logic        ras_overflow, ret_miss;

  int total = 0;
  int bad   = 0;

  fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .INSTR_BYTES(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .jump_valid(jump_valid), .jump_addr(jump_addr),
    .call(call), .call_ret_addr(call_ret_addr), .ret(ret),
    .pc(pc), .ras_count(ras_count), .ras_overflow(ras_overflow), .ret_miss(ret_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; stall = 0; redirect_valid = 0; jump_valid = 0; call = 0; ret = 0;
    redirect_addr = '0; jump_addr = '0; call_ret_addr = '0;
  endtask

  // One active (falling) edge, then settle before checking.
  task automatic edge_();
    @(negedge clk); #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] epc, input int ecnt,
                           input logic eovf, input logic emiss);
    chk({tag, ".pc"},   pc, epc);
    chk({tag, ".cnt"},  32'(ras_count), 32'(ecnt));
    chk({tag, ".ovf"},  32'(ras_overflow), 32'(eovf));
    chk({tag, ".miss"}, 32'(ret_miss), 32'(emiss));
  endtask

  initial begin
    idle();
    // 1: reset two edges, then sequential fetch
    rst = 1; edge_(); edge_();
    chk_state("rst", 32'h100, 0, 0, 0);
    rst = 0; edge_(); chk("inc1", pc, 32'h104);
    edge_();          chk("inc2", pc, 32'h108);

    // 2: stall holds, jump overrides stall and is aligned
    stall = 1;
    for (int i = 0; i < 3; i++) begin edge_(); chk("stall", pc, 32'h108); end
    jump_valid = 1; jump_addr = 32'h203; edge_();
    chk("jmp_stall", pc, 32'h200);
    idle();

    // 3: redirect beats jump/ret/call; call and ret suppressed
    redirect_valid = 1; redirect_addr = 32'h400; jump_valid = 1; jump_addr = 32'h500;
    ret = 1; call = 1; call_ret_addr = 32'h77; edge_();
    chk_state("redir", 32'h400, 0, 0, 0);
    idle();

    // 4: five calls overflow a 4-deep RAS
    for (int i = 1; i <= 5; i++) begin
      call = 1; call_ret_addr = 32'(i * 16); edge_();
      chk("call.pc", pc, 32'h400 + 32'(i * 4));
      chk("call.cnt", 32'(ras_count), (i > 4) ? 32'd4 : 32'(i));
      chk("call.ovf", 32'(ras_overflow), (i > 4) ? 32'd1 : 32'd0);
    end
    call = 0; ret = 1;
    edge_(); chk_state("ret1", 32'h50, 3, 1, 0);
    edge_(); chk_state("ret2", 32'h40, 2, 1, 0);
    edge_(); chk_state("ret3", 32'h30, 1, 1, 0);
    edge_(); chk_state("ret4", 32'h20, 0, 1, 0);
    edge_(); chk_state("ret5", 32'h24, 0, 1, 1);
    ret = 0; edge_(); chk_state("miss_clr", 32'h28, 0, 1, 0);

    // 5: call+ret swap with one entry
    call = 1; call_ret_addr = 32'h80; edge_();
    chk_state("push80", 32'h2C, 1, 1, 0);
    call_ret_addr = 32'h90; ret = 1; edge_();
    chk_state("swap", 32'h80, 1, 1, 0);
    call = 0; edge_();
    chk_state("pop90", 32'h90, 0, 1, 0);
    ret = 0;

    // 6: address wrap, call+ret on empty RAS, mid-run reset
    redirect_valid = 1; redirect_addr = 32'hFFFF_FFFF; edge_();
    chk("redir_align", pc, 32'hFFFF_FFFC);
    idle(); edge_(); chk("wrap", pc, 32'h0);
    call = 1; ret = 1; call_ret_addr = 32'hA0; edge_();
    chk_state("cr_empty", 32'h4, 1, 1, 1);
    idle(); rst = 1; call = 1; call_ret_addr = 32'hB0; edge_();
    chk_state("rst_mid", 32'h100, 0, 0, 0);
    idle(); ret = 1; edge_();
    chk_state("post_rst_ret", 32'h104, 0, 0, 1);
    idle(); edge_();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
